// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder: stalls the MEM stage for LATENCY cycles, then answers.
// Optional access/stall statistics counters are built when DMEM_STATS_EN is defined.
module dmem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        MemRead_i,
  input  logic        MemWrite_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic        stall_o,
  output logic        done_o,
  output logic        err_o
`ifdef DMEM_STATS_EN
  ,
  output logic [31:0] rd_cnt_o,
  output logic [31:0] wr_cnt_o,
  output logic [31:0] stall_cnt_o
`endif
);

  localparam int IDXW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t      state, state_nxt;
  logic [7:0]  count, count_nxt;
  logic [31:0] addr_q, data_q;
  logic        wr_q, both_q;
  logic [31:0] acc_addr, acc_data;
  logic        acc_wr, acc_both;
  logic        req, enter_done, bad_addr, acc_err;
  logic [IDXW-1:0] idx;
  logic [31:0] memory [DEPTH_WORDS];

  assign req = MemRead_i | MemWrite_i;

  always_comb begin
    state_nxt = state;
    count_nxt = count;
    stall_o   = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          stall_o   = 1'b1;
          count_nxt = 8'(LATENCY - 1);
          state_nxt = (LATENCY == 1) ? DONE : BUSY;
        end
      end
      BUSY: begin
        stall_o   = 1'b1;
        count_nxt = count - 8'd1;
        if (count == 8'd1) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (rst_i) stall_o = 1'b0;
  end

  assign done_o = (state == DONE);

  // With LATENCY==1 the access completes on the accept edge, so use the live inputs in IDLE.
  assign acc_addr = (state == IDLE) ? addr_i : addr_q;
  assign acc_data = (state == IDLE) ? data_i : data_q;
  assign acc_wr   = (state == IDLE) ? MemWrite_i : wr_q;
  assign acc_both = (state == IDLE) ? (MemRead_i & MemWrite_i) : both_q;

  assign bad_addr   = (acc_addr[1:0] != 2'b00) ||
                      ({2'b00, acc_addr[31:2]} >= 32'(DEPTH_WORDS));
  assign acc_err    = bad_addr | acc_both;
  assign idx        = acc_addr[IDXW+1:2];
  assign enter_done = (state_nxt == DONE) && (state != DONE) && !rst_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state  <= IDLE;
      count  <= 8'd0;
      addr_q <= 32'd0;
      data_q <= 32'd0;
      wr_q   <= 1'b0;
      both_q <= 1'b0;
      data_o <= 32'd0;
      err_o  <= 1'b0;
    end else begin
      state <= state_nxt;
      count <= count_nxt;
      if (state == IDLE && req) begin
        addr_q <= addr_i;
        data_q <= data_i;
        wr_q   <= MemWrite_i;
        both_q <= MemRead_i & MemWrite_i;
      end
      if (enter_done) begin
        err_o <= acc_err;
        if (acc_err)     data_o <= 32'd0;
        else if (!acc_wr) data_o <= memory[idx];
      end
    end
  end

  // Memory has no reset so its contents survive rst_i.
  always_ff @(posedge clk_i) begin
    if (enter_done && acc_wr && !bad_addr) memory[idx] <= acc_data;
  end

`ifdef DMEM_STATS_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_cnt_o    <= 32'd0;
      wr_cnt_o    <= 32'd0;
      stall_cnt_o <= 32'd0;
    end else begin
      if (enter_done && !acc_wr && rd_cnt_o != 32'hFFFF_FFFF) rd_cnt_o <= rd_cnt_o + 32'd1;
      if (enter_done && acc_wr && wr_cnt_o != 32'hFFFF_FFFF)  wr_cnt_o <= wr_cnt_o + 32'd1;
      if (stall_o && stall_cnt_o != 32'hFFFF_FFFF) stall_cnt_o <= stall_cnt_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: a LATENCY=4 and a LATENCY=1 instance checked every cycle against
// a transaction-level model, plus literal expectations for the directed scenarios.
module tb_dmem_responder;
  localparam int L0 = 4;
  localparam int L1 = 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic        rd [2];
  logic        wr [2];
  logic [31:0] addr [2];
  logic [31:0] wd [2];
  logic [31:0] q0, q1;
  logic stall0, stall1, done0, done1, err0, err1;
`ifdef DMEM_STATS_EN
  logic [31:0] rc0, wc0, sc0, rc1, wc1, sc1;
`endif

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(L0)) dut0 (
    .clk_i(clk), .rst_i(rst), .MemRead_i(rd[0]), .MemWrite_i(wr[0]),
    .addr_i(addr[0]), .data_i(wd[0]), .data_o(q0), .stall_o(stall0),
    .done_o(done0), .err_o(err0)
`ifdef DMEM_STATS_EN
    , .rd_cnt_o(rc0), .wr_cnt_o(wc0), .stall_cnt_o(sc0)
`endif
  );

  dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(L1)) dut1 (
    .clk_i(clk), .rst_i(rst), .MemRead_i(rd[1]), .MemWrite_i(wr[1]),
    .addr_i(addr[1]), .data_i(wd[1]), .data_o(q1), .stall_o(stall1),
    .done_o(done1), .err_o(err1)
`ifdef DMEM_STATS_EN
    , .rd_cnt_o(rc1), .wr_cnt_o(wc1), .stall_cnt_o(sc1)
`endif
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Transaction-level model: one outstanding access per instance, timed in whole cycles.
  logic [31:0] mm [2][1024];
  int   lat [2] = '{L0, L1};
  int   cyc = 0;
  bit   pend [2];
  int   tacc [2];
  bit   m_wr [2], m_err [2], m_valid [2], m_chkd [2];
  logic [31:0] m_data [2], m_wd [2];
  int   m_idx [2];
  int   rcm [2], wcm [2], scm [2];

  always @(negedge clk) begin
    cyc++;
    for (int k = 0; k < 2; k++) begin
      logic [31:0] aq;
      logic as, ad, ae;
      bit es, ed;
      aq = (k == 0) ? q0 : q1;
      as = (k == 0) ? stall0 : stall1;
      ad = (k == 0) ? done0 : done1;
      ae = (k == 0) ? err0 : err1;
      if (rst) begin
        pend[k] = 1'b0;
        rcm[k] = 0; wcm[k] = 0; scm[k] = 0;
        chk($sformatf("rst_stall%0d", k), {31'd0, as}, 32'd0);
        chk($sformatf("rst_done%0d", k), {31'd0, ad}, 32'd0);
        chk($sformatf("rst_err%0d", k), {31'd0, ae}, 32'd0);
        chk($sformatf("rst_data%0d", k), aq, 32'd0);
      end else begin
        if (!pend[k] && (rd[k] || wr[k])) begin
          pend[k]    = 1'b1;
          tacc[k]    = cyc;
          m_wr[k]    = wr[k];
          m_wd[k]    = wd[k];
          m_valid[k] = (addr[k][1:0] == 2'b00) && (addr[k] / 4 < 1024);
          m_err[k]   = !m_valid[k] || (rd[k] && wr[k]);
          m_idx[k]   = int'(addr[k][11:2]);
          m_chkd[k]  = m_err[k] || !wr[k];
          m_data[k]  = m_err[k] ? 32'd0 : mm[k][m_idx[k]];
        end
        es = pend[k] && (cyc < tacc[k] + lat[k]);
        ed = pend[k] && (cyc == tacc[k] + lat[k]);
        if (es) scm[k]++;
        chk($sformatf("stall%0d", k), {31'd0, as}, {31'd0, es});
        chk($sformatf("done%0d", k), {31'd0, ad}, {31'd0, ed});
        if (ed) begin
          chk($sformatf("err%0d", k), {31'd0, ae}, {31'd0, m_err[k]});
          if (m_chkd[k]) chk($sformatf("data%0d", k), aq, m_data[k]);
          if (m_wr[k] && m_valid[k]) mm[k][m_idx[k]] = m_wd[k];
          if (m_wr[k]) wcm[k]++; else rcm[k]++;
          pend[k] = 1'b0;
        end
      end
    end
  end

  task automatic acc(input int k, input logic r, input logic w, input logic [31:0] a,
                     input logic [31:0] d, output logic [31:0] dq, output logic de,
                     output int lt);
    @(posedge clk); #1;
    rd[k] = r; wr[k] = w; addr[k] = a; wd[k] = d;
    @(posedge clk); #1;
    rd[k] = 1'b0; wr[k] = 1'b0;
    lt = -1; dq = 32'd0; de = 1'b0;
    for (int i = 1; i <= 300; i++) begin
      @(negedge clk);
      if ((k == 0) ? done0 : done1) begin
        lt = i;
        dq = (k == 0) ? q0 : q1;
        de = (k == 0) ? err0 : err1;
        break;
      end
    end
    if (lt < 0) begin
      nvec++; nerr++;
      $display("FAIL acc_timeout inst %0d addr %h: no done within 300 cycles", k, a);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] dq;
    logic de;
    int lt, ndone;
    for (int k = 0; k < 2; k++) begin
      rd[k] = 1'b0; wr[k] = 1'b0; addr[k] = 32'd0; wd[k] = 32'd0;
      pend[k] = 1'b0; rcm[k] = 0; wcm[k] = 0; scm[k] = 0;
    end
    for (int i = 0; i < 1024; i++) begin
      mm[0][i] = 32'(i) * 32'h0101_0101 + 32'hC0DE_0000;
      mm[1][i] = mm[0][i];
      dut0.memory[i] = mm[0][i];
      dut1.memory[i] = mm[0][i];
    end
    mm[0][3] = 32'hDEAD_BEEF;
    dut0.memory[3] = 32'hDEAD_BEEF;

    #1 rst = 1'b1;
    @(posedge clk); @(posedge clk); #1 rst = 1'b0;

    // Aligned load of a preloaded word
    acc(0, 1'b1, 1'b0, 32'h0C, 32'd0, dq, de, lt);
    chk("t1_lat", lt, 4);
    chk("t1_data", dq, 32'hDEAD_BEEF);
    chk("t1_err", {31'd0, de}, 32'd0);

    // Store then read back
    acc(0, 1'b0, 1'b1, 32'h10, 32'h1234_5678, dq, de, lt);
    chk("t2_st_err", {31'd0, de}, 32'd0);
    acc(0, 1'b1, 1'b0, 32'h10, 32'd0, dq, de, lt);
    chk("t2_ld_data", dq, 32'h1234_5678);

`ifdef DMEM_STATS_EN
    chk("t6_rd_cnt", rc0, 32'd2);
    chk("t6_wr_cnt", wc0, 32'd1);
    chk("t6_stall_cnt", sc0, 32'd12);
`endif

    // Misaligned and out-of-range accesses
    acc(0, 1'b1, 1'b0, 32'h0E, 32'd0, dq, de, lt);
    chk("t3_mis_lat", lt, 4);
    chk("t3_mis_err", {31'd0, de}, 32'd1);
    chk("t3_mis_data", dq, 32'd0);
    acc(0, 1'b1, 1'b0, 32'h1000, 32'd0, dq, de, lt);
    chk("t3_oor_err", {31'd0, de}, 32'd1);
    chk("t3_oor_data", dq, 32'd0);
    acc(0, 1'b1, 1'b0, 32'h0C, 32'd0, dq, de, lt);
    chk("t3_unchanged", dq, 32'hDEAD_BEEF);
    acc(0, 1'b0, 1'b1, 32'h41, 32'hFFFF_FFFF, dq, de, lt);
    chk("t3_mis_st_err", {31'd0, de}, 32'd1);
    acc(0, 1'b1, 1'b0, 32'h40, 32'd0, dq, de, lt);
    chk("t3_mis_st_mem", dq, 32'hD0EE_1010);

    // Read and write together: error, but the store still commits
    acc(0, 1'b1, 1'b1, 32'h30, 32'h0BAD_F00D, dq, de, lt);
    chk("both_err", {31'd0, de}, 32'd1);
    chk("both_data", dq, 32'd0);
    acc(0, 1'b1, 1'b0, 32'h30, 32'd0, dq, de, lt);
    chk("both_commit", dq, 32'h0BAD_F00D);
    chk("both_rd_err", {31'd0, de}, 32'd0);

    // Reset during a pending store
    @(posedge clk); #1;
    wr[0] = 1'b1; addr[0] = 32'h20; wd[0] = 32'hAAAA_5555;
    @(posedge clk); #1 wr[0] = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    #1 chk("t4_stall_in_rst", {31'd0, stall0}, 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    chk("t4_mem8", dut0.memory[8], 32'hC8E6_0808);
    acc(0, 1'b1, 1'b0, 32'h20, 32'd0, dq, de, lt);
    chk("t4_ld_lat", lt, 4);
    chk("t4_ld_data", dq, 32'hC8E6_0808);

    // LATENCY=1: request held high gives one access every two cycles
    @(posedge clk); #1;
    rd[1] = 1'b1; addr[1] = 32'h0C;
    ndone = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done1) begin
        ndone++;
        chk("t5_data", q1, 32'hC3E1_0303);
      end
    end
    @(posedge clk); #1 rd[1] = 1'b0;
    chk("t5_ndone", ndone, 4);
    acc(1, 1'b0, 1'b1, 32'h44, 32'h600D_CAFE, dq, de, lt);
    chk("t5_st_lat", lt, 1);
    acc(1, 1'b1, 1'b0, 32'h44, 32'd0, dq, de, lt);
    chk("t5_ld_data", dq, 32'h600D_CAFE);

    repeat (3) @(negedge clk);
`ifdef DMEM_STATS_EN
    chk("rd_cnt0", rc0, 32'(rcm[0]));
    chk("wr_cnt0", wc0, 32'(wcm[0]));
    chk("stall_cnt0", sc0, 32'(scm[0]));
    chk("rd_cnt1", rc1, 32'(rcm[1]));
    chk("wr_cnt1", wc1, 32'(wcm[1]));
    chk("stall_cnt1", sc1, 32'(scm[1]));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
